// File: rtl/rv_mem_arb_if.sv
// Bundle of the fetch, data and memory handshakes around the rv unified-memory arbiter.
// The arbiter sits on the slave modport; requesters and memory sit on the master side.
interface rv_mem_arb_if #(
    parameter int DW = 64,
    parameter int AW = 64
);
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_data;

    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;

    logic          m_req_valid;
    logic          m_req_we;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_wdata;
    logic          m_req_ready;
    logic          m_rsp_valid;
    logic [DW-1:0] m_rsp_data;

    logic          busy;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output m_req_valid, m_req_we, m_req_addr, m_req_wdata,
        input  m_req_ready, m_rsp_valid, m_rsp_data,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  m_req_valid, m_req_we, m_req_addr, m_req_wdata,
        output m_req_ready, m_rsp_valid, m_rsp_data,
        input  busy
    );
endinterface

// File: rtl/rv_mem_arb.sv
// Shares one single-ported memory between fetch and data ports, one access in flight.
// Data wins by default; fetch is forced after MAX_WAIT consecutive data wins while it waits.
module rv_mem_arb #(
    parameter int DW       = 64,
    parameter int AW       = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rv_mem_arb_if.slave  bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          owner_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          force_if, grant_d, grant_if;

    assign force_if = bus.if_req_valid && (starve_cnt == CW'(MAX_WAIT));
    assign grant_d  = (state == IDLE) && bus.d_req_valid && !force_if;
    assign grant_if = (state == IDLE) && bus.if_req_valid && !grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_d || grant_if) state_nxt = REQ;
            REQ:     if (bus.m_req_ready)     state_nxt = RSP;
            RSP:     if (bus.m_rsp_valid)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are gated by reset so every output reads 0 while rst_n is low.
    always_comb begin
        bus.if_req_ready = rst_n && grant_if;
        bus.d_req_ready  = rst_n && grant_d;
        bus.m_req_valid  = (state == REQ);
        bus.busy         = (state != IDLE);
    end

    assign bus.m_req_we    = we_q;
    assign bus.m_req_addr  = addr_q;
    assign bus.m_req_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (grant_d) begin
            owner_d <= 1'b1;
            we_q    <= bus.d_req_we;
            addr_q  <= bus.d_req_addr;
            wdata_q <= bus.d_req_wdata;
            if (bus.if_req_valid && starve_cnt != CW'(MAX_WAIT))
                starve_cnt <= starve_cnt + 1'b1;
        end else if (grant_if) begin
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= bus.if_req_addr;
            starve_cnt <= '0;
        end
    end

    // Response capture only in RSP; stray m_rsp_valid elsewhere is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rsp_valid <= 1'b0;
            bus.if_rsp_data  <= '0;
            bus.d_rsp_valid  <= 1'b0;
            bus.d_rsp_data   <= '0;
        end else begin
            bus.if_rsp_valid <= 1'b0;
            bus.d_rsp_valid  <= 1'b0;
            if (state == RSP && bus.m_rsp_valid) begin
                if (owner_d) begin
                    bus.d_rsp_valid <= 1'b1;
                    bus.d_rsp_data  <= we_q ? '0 : bus.m_rsp_data;
                end else begin
                    bus.if_rsp_valid <= 1'b1;
                    bus.if_rsp_data  <= bus.m_rsp_data[31:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: small memory model plus hand-computed expectations.
module tb_rv_mem_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_mem_arb_if #(.DW(64), .AW(64)) mif();
    rv_mem_arb #(.DW(64), .AW(64), .MAX_WAIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(mif));

    int nvec = 0, nerr = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // memory model: responds the cycle after acceptance, optional stall / hold / spurious pulse
    logic [63:0] mem [logic [63:0]];
    int   stall = 0;
    bit   hold_rsp = 0, spur = 0, rsp_pend = 0;
    logic [63:0] rsp_q;
    always @(negedge clk) begin
        mif.m_rsp_valid = 1'b0;
        if (spur) begin mif.m_rsp_valid = 1'b1; mif.m_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0; end
        if (rsp_pend && !hold_rsp) begin
            mif.m_rsp_valid = 1'b1; mif.m_rsp_data = rsp_q; rsp_pend = 0;
        end
        mif.m_req_ready = 1'b0;
        if (mif.m_req_valid && !rsp_pend) begin
            if (stall > 0) stall--;
            else begin
                mif.m_req_ready = 1'b1;
                if (mif.m_req_we) begin mem[mif.m_req_addr] = mif.m_req_wdata; rsp_q = '1; end
                else rsp_q = mem.exists(mif.m_req_addr) ? mem[mif.m_req_addr] : 64'h0;
                rsp_pend = 1;
            end
        end
    end

    // response and grant monitors
    int if_cnt = 0, d_cnt = 0, if_cyc = 0, gn = 0;
    logic [31:0] if_dat;
    logic [63:0] d_dat, gbits = '0;
    always @(negedge clk) begin
        if (mif.if_rsp_valid) begin if_cnt++; if_dat = mif.if_rsp_data; if_cyc = cyc; end
        if (mif.d_rsp_valid)  begin d_cnt++;  d_dat = mif.d_rsp_data; end
        if (mif.d_req_ready)  begin gbits = {gbits[62:0], 1'b1}; gn++; end
        if (mif.if_req_ready) begin gbits = {gbits[62:0], 1'b0}; gn++; end
    end

    // called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic req(input bit is_d, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, output int t);
        bit ok = 0;
        t = -1;
        if (is_d) begin
            mif.d_req_valid = 1; mif.d_req_we = we; mif.d_req_addr = addr; mif.d_req_wdata = wdata;
        end else begin
            mif.if_req_valid = 1; mif.if_req_addr = addr;
        end
        for (int i = 0; i < 50; i++) begin
            #1;
            if (is_d ? mif.d_req_ready : mif.if_req_ready) begin ok = 1; t = cyc; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("req_timeout", 0, 1);
        else begin @(posedge clk); #1; end
        if (is_d) mif.d_req_valid = 0; else mif.if_req_valid = 0;
    endtask

    task automatic wait_rsp(input bit is_d, input int n0, input string tag);
        for (int i = 0; i < 30; i++) begin
            if ((is_d ? d_cnt : if_cnt) > n0) break;
            @(posedge clk);
        end
        @(posedge clk); #1;
        chk(tag, is_d ? d_cnt : if_cnt, n0 + 1);
    endtask

    initial begin
        int t, n0;
        mif.if_req_valid = 1; mif.if_req_addr = '0;
        mif.d_req_valid = 1;  mif.d_req_we = 0; mif.d_req_addr = '0; mif.d_req_wdata = '0;
        mif.m_req_ready = 0;  mif.m_rsp_valid = 0; mif.m_rsp_data = '0;
        mem[64'h40] = 64'h0000_0000_0000_0013;
        mem[64'h80] = 64'h0000_0000_0000_CAFE;
        mem[64'h300] = 64'h0;
        #2;
        chk("rst_busy", mif.busy, 0);
        chk("rst_mvalid", mif.m_req_valid, 0);
        chk("rst_ready", {mif.if_req_ready, mif.d_req_ready}, 0);
        chk("rst_rsp", {mif.if_rsp_valid, mif.d_rsp_valid}, 0);
        mif.if_req_valid = 0; mif.d_req_valid = 0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // 1: fetch only
        req(0, 0, 64'h40, 0, t);
        chk("f_mvalid", mif.m_req_valid, 1);
        chk("f_maddr", mif.m_req_addr, 64'h40);
        chk("f_mwe", mif.m_req_we, 0);
        wait_rsp(0, 0, "f_rsp_cnt");
        chk("f_data", if_dat, 32'h13);
        chk("f_latency", if_cyc - t, 3);

        // 2: store then load
        req(1, 1, 64'h100, 64'hDEADBEEF, t);
        chk("st_mwe", mif.m_req_we, 1);
        chk("st_mwdata", mif.m_req_wdata, 64'hDEADBEEF);
        wait_rsp(1, 0, "st_rsp_cnt");
        chk("st_ack_data", d_dat, 0);
        req(1, 0, 64'h100, 0, t);
        chk("ld_mwe", mif.m_req_we, 0);
        wait_rsp(1, 1, "ld_rsp_cnt");
        chk("ld_data", d_dat, 64'hDEADBEEF);
        repeat (3) @(posedge clk); #1;
        chk("d_pulse_total", d_cnt, 2);

        // 3: starvation, both ports requesting every cycle
        gn = 0; gbits = '0;
        mif.if_req_addr = 64'h40; mif.d_req_addr = 64'h300; mif.d_req_we = 0;
        mif.if_req_valid = 1; mif.d_req_valid = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (gn >= 10) break;
        end
        #1 mif.if_req_valid = 0; mif.d_req_valid = 0;
        chk("starve_gn", gn, 10);
        chk("starve_order", gbits[9:0], 10'b1111011110);
        repeat (4) @(posedge clk); #1;

        // 4: backpressure
        n0 = d_cnt;
        stall = 5;
        req(1, 1, 64'h200, 64'h1234, t);
        mif.if_req_addr = 64'h80; mif.if_req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_stable", {mif.m_req_valid, mif.m_req_we, mif.busy, mif.if_req_ready, mif.d_req_ready},
                5'b11100);
            chk("bp_addr", mif.m_req_addr, 64'h200);
            chk("bp_wdata", mif.m_req_wdata, 64'h1234);
            @(posedge clk); #1;
        end
        req(0, 0, 64'h80, 0, t);
        chk("bp_d_done", d_cnt, n0 + 1);
        wait_rsp(0, if_cnt - ((cyc - t) >= 3 ? 1 : 0), "bp_if_rsp");
        chk("bp_if_data", if_dat, 32'hCAFE);

        // 5: reset while waiting in RSP
        n0 = d_cnt;
        hold_rsp = 1;
        req(1, 0, 64'h100, 64'h5555, t);
        @(posedge clk); #1;
        chk("rr_in_rsp", {mif.busy, mif.m_req_valid}, 2'b10);
        rst_n = 0;
        #1;
        chk("rr_busy", mif.busy, 0);
        chk("rr_maddr", mif.m_req_addr, 0);
        chk("rr_mwdata", mif.m_req_wdata, 0);
        chk("rr_if_data", mif.if_rsp_data, 0);
        hold_rsp = 0;
        repeat (2) @(posedge clk); #1 rst_n = 1;
        repeat (3) @(posedge clk); #1;
        chk("rr_no_pulse", d_cnt, n0);
        n0 = if_cnt;
        req(0, 0, 64'h40, 0, t);
        wait_rsp(0, n0, "rr_accept");
        chk("rr_data", if_dat, 32'h13);

        // 6: spurious m_rsp_valid in IDLE then in REQ
        n0 = if_cnt;
        spur = 1; @(posedge clk); #1 spur = 0;
        @(posedge clk); #1;
        chk("sp_idle", {mif.busy, mif.if_rsp_valid, mif.d_rsp_valid}, 0);
        stall = 3;
        req(0, 0, 64'h40, 0, t);
        spur = 1; @(posedge clk); #1 spur = 0;
        chk("sp_req_hold", mif.m_req_valid, 1);
        chk("sp_req_cnt", if_cnt, n0);
        wait_rsp(0, n0, "sp_rsp");
        chk("sp_data", if_dat, 32'h13);
        repeat (3) @(posedge clk); #1;
        chk("sp_single", if_cnt, n0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
